// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [2:0]  dop,
   input  logic [31:0] dm_addr,
   input  logic [31:0] data_in,
   output logic [31:0] rdata,
   output logic        sel,
   output logic        tx,
   output logic        busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
   localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic [1:0]    r_st;
   logic [BW-1:0] r_bcnt;
   logic [2:0]    r_bidx;
   logic [7:0]    r_shift;
   logic          r_tx, r_ovf;
   logic          w_push_req, w_clr, w_empty, w_full, w_bit_end, w_pop, w_push, w_unused;
   assign sel        = dm_addr[31:3] == BASE_ADDR[31:3];
   assign w_push_req = we & sel & ~dm_addr[2];
   assign w_clr      = we & sel & dm_addr[2];
   assign w_empty    = r_cnt == '0;
   assign w_full     = r_cnt == DEPTH;
   assign w_bit_end  = r_bcnt == '0;
   // a pop on the stop-bit end frees a slot, so a push on that edge is still accepted when full
   assign w_pop      = ~w_empty & ((r_st == S_IDLE) | ((r_st == S_STOP) & w_bit_end));
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign rdata      = (sel & dm_addr[2]) ? {28'b0, r_ovf, w_full, w_empty, r_st != S_IDLE} : '0;
   assign tx         = r_tx;
   assign busy       = (r_st != S_IDLE) | ~w_empty;
   assign w_unused   = ^{dop, data_in[31:8], dm_addr[1:0]};
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= data_in[7:0];
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
         r_ovf <= (w_push_req & ~w_push) | (r_ovf & ~w_clr);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_st    <= S_IDLE;
         r_tx    <= 1'b1;
         r_bcnt  <= '0;
         r_bidx  <= '0;
         r_shift <= '0;
      end else begin
         case (r_st)
            S_IDLE:
               if (w_pop) begin
                  r_st    <= S_START;
                  r_shift <= r_mem[r_rp];
                  r_bcnt  <= BMAX;
                  r_tx    <= 1'b0;
               end
            S_START:
               if (!w_bit_end) r_bcnt <= r_bcnt - BW'(1);
               else begin
                  r_st   <= S_DATA;
                  r_bidx <= '0;
                  r_bcnt <= BMAX;
                  r_tx   <= r_shift[0];
               end
            S_DATA:
               if (!w_bit_end) r_bcnt <= r_bcnt - BW'(1);
               else begin
                  r_bcnt <= BMAX;
                  if (r_bidx == 3'd7) begin
                     r_st <= S_STOP;
                     r_tx <= 1'b1;
                  end else begin
                     r_bidx  <= r_bidx + 3'd1;
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end
            S_STOP:
               if (!w_bit_end) r_bcnt <= r_bcnt - BW'(1);
               else if (w_pop) begin
                  r_st    <= S_START;
                  r_shift <= r_mem[r_rp];
                  r_bcnt  <= BMAX;
                  r_tx    <= 1'b0;
               end else r_st <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE = 32'h1000_0000;
   logic        clk = 1'b0, reset = 1'b1, we = 1'b0;
   logic [2:0]  dop = 3'b010;
   logic [31:0] dm_addr = '0, data_in = '0, rdata;
   logic        sel, tx, busy;
   logic [199:0] cap;
   int total = 0, bad = 0, ci = -1, z;
   mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .we(we), .dop(dop), .dm_addr(dm_addr), .data_in(data_in),
      .rdata(rdata), .sel(sel), .tx(tx), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      if (ci >= 0 && ci < 200) cap[ci] = tx;
      ci++;
   endtask
   task automatic st(input logic [31:0] a, input logic [31:0] d);
      we = 1'b1;
      dm_addr = a;
      data_in = d;
      tick();
      we = 1'b0;
   endtask
   task automatic stat(input string tag, input logic [31:0] exp);
      dm_addr = BASE + 32'd4;
      #1;
      chk(tag, rdata, exp);
   endtask
   // start bit, 8 data bits LSB first, stop bit; 4 samples per bit, earliest sample in bit 0
   function automatic logic [39:0] frame(input logic [7:0] b);
      logic [39:0] f;
      logic bit_v;
      for (int c = 0; c < 10; c++) begin
         bit_v = (c == 0) ? 1'b0 : (c == 9) ? 1'b1 : b[c-1];
         for (int r = 0; r < 4; r++) f[c*4+r] = bit_v;
      end
      return f;
   endfunction
   initial begin
      repeat (2) tick();
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      stat("rst_status", 32'h2);
      chk("rst_sel", sel, 1);
      reset = 1'b0;
      tick();
      ci = -1;
      st(BASE, 32'h55);
      chk("t1_tx_after_push", tx, 1);
      chk("t1_busy_after_push", busy, 1);
      repeat (41) tick();
      chk("t1_tx_low_next", cap[0], 0);
      chk("t1_frame", cap[39:0], frame(8'h55));
      chk("t1_idle_busy", busy, 0);
      ci = -1;
      st(BASE, 32'h41);
      st(BASE + 32'd1, 32'h42);
      st(BASE + 32'd2, 32'h43);
      st(BASE + 32'd3, 32'h44);
      repeat (158) tick();
      chk("t2_frame0", cap[39:0], frame(8'h41));
      chk("t2_frame1", cap[79:40], frame(8'h42));
      chk("t2_frame2", cap[119:80], frame(8'h43));
      chk("t2_frame3", cap[159:120], frame(8'h44));
      chk("t2_busy", busy, 0);
      stat("t2_status", 32'h2);
      for (int i = 0; i < 6; i++) st(BASE, 32'h60 + i);
      stat("t3_ovf_full", 32'hD);
      st(BASE + 32'd4, 32'hFFFF_FFFF);
      stat("t3_ovf_clr", 32'h5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      stat("t3_after_rst", 32'h2);
      ci = -1;
      st(BASE, 32'hA5);
      st(BASE, 32'h11);
      st(BASE, 32'h22);
      repeat (11) tick();
      chk("t4_partial", cap[11:0], 64'(frame(8'hA5) & 40'hFFF));
      stat("t4_mid_status", 32'h1);
      reset = 1'b1;
      tick();
      chk("t4_tx_rst", tx, 1);
      chk("t4_busy_rst", busy, 0);
      stat("t4_status_rst", 32'h2);
      reset = 1'b0;
      z = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (tx == 1'b0) z++;
      end
      chk("t4_no_frames", z, 0);
      dm_addr = BASE + 32'd8;
      #1;
      chk("t5_sel_b8", sel, 0);
      st(BASE + 32'd8, 32'h77);
      dm_addr = 32'h0000_0100;
      #1;
      chk("t5_sel_100", sel, 0);
      chk("t5_rdata_unsel", rdata, 0);
      st(32'h0000_0100, 32'h78);
      z = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (tx == 1'b0) z++;
      end
      chk("t5_tx_idle", z, 0);
      chk("t5_busy", busy, 0);
      stat("t5_status", 32'h2);
      dm_addr = BASE;
      #1;
      chk("t5_txdata_rd", rdata, 0);
      ci = -1;
      st(BASE, 32'h3C);
      st(BASE, 32'hC3);
      repeat (39) tick();
      st(BASE, 32'h5A);
      stat("t6_status_edge", 32'h1);
      repeat (80) tick();
      chk("t6_frame0", cap[39:0], frame(8'h3C));
      chk("t6_frame1", cap[79:40], frame(8'hC3));
      chk("t6_frame2", cap[119:80], frame(8'h5A));
      chk("t6_busy", busy, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
